// File: rtl/txhexn_if.sv
// Request and byte-stream signals of the hex word printer, grouped as one bundle.
// The master side issues words and reports transmitter busy; the slave is txhexn.
interface txhexn_if #(
  parameter int NHEX = 8
);
  logic              i_stb;
  logic [4*NHEX-1:0] i_data;
  logic              o_busy;
  logic              o_done;
  logic              o_tx_stb;
  logic [7:0]        o_tx_data;
  logic              i_tx_busy;

  modport master (
    output i_stb, i_data, i_tx_busy,
    input  o_busy, o_done, o_tx_stb, o_tx_data
  );

  modport slave (
    input  i_stb, i_data, i_tx_busy,
    output o_busy, o_done, o_tx_stb, o_tx_data
  );
endinterface

// File: rtl/txhexn.sv
// Prints one word as ASCII hex ("0x" prefix, digits, line ending) into a
// byte-serial transmitter, one byte per accepted handshake.
module txhexn #(
  parameter int NHEX   = 8,
  parameter int PREFIX = 1,
  parameter int EOL    = 2,
  parameter int UPPER  = 0,
  parameter int ZSUP   = 0
) (
  input  logic    i_clk,
  input  logic    i_reset_n,
  txhexn_if.slave bus
);
  localparam int CW = $clog2(NHEX + 1);
  localparam int DW = 4 * NHEX;

  typedef enum logic [2:0] {IDLE, PFX0, PFXX, DIGIT, CR, LF} state_t;

  localparam state_t FIRST       = state_t'((PREFIX != 0) ? PFX0 : DIGIT);
  localparam state_t AFTER_DIGIT = state_t'((EOL == 2) ? CR : ((EOL == 1) ? LF : IDLE));

  state_t          state_q, state_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [CW-1:0]   lz;
  logic            accept;
  logic [3:0]      nib;
  logic [7:0]      tx_byte;

  assign accept = bus.o_tx_stb && !bus.i_tx_busy;

  // Leading-zero nibble count, capped so that an all-zero word still prints one "0".
  always_comb begin
    logic seen;
    seen = 1'b0;
    lz   = '0;
    if (ZSUP != 0) begin
      for (int i = NHEX - 1; i >= 1; i--) begin
        if (!seen && bus.i_data[4*i +: 4] == 4'h0) lz = lz + CW'(1);
        else                                        seen = 1'b1;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_stb) begin
          state_d = FIRST;
          sr_d    = bus.i_data << (4 * lz);
          cnt_d   = CW'(NHEX) - lz;
        end
      end
      PFX0:  if (accept) state_d = PFXX;
      PFXX:  if (accept) state_d = DIGIT;
      DIGIT: begin
        if (accept) begin
          sr_d  = sr_q << 4;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = AFTER_DIGIT;
        end
      end
      CR:      if (accept) state_d = LF;
      LF:      if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept && state_d == IDLE) done_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Output byte is a pure function of held state, so it cannot move during a stall.
  always_comb begin
    nib     = sr_q[DW-1 -: 4];
    tx_byte = 8'h00;
    case (state_q)
      PFX0:  tx_byte = 8'h30;
      PFXX:  tx_byte = 8'h78;
      DIGIT: begin
        if (nib < 4'd10) tx_byte = 8'h30 + {4'h0, nib};
        else             tx_byte = ((UPPER != 0) ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
      end
      CR:      tx_byte = 8'h0D;
      LF:      tx_byte = 8'h0A;
      default: tx_byte = 8'h00;
    endcase
  end

  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_tx_stb  = (state_q != IDLE);
  assign bus.o_tx_data = tx_byte;
  assign bus.o_done    = done_q;

endmodule

// File: doc/txhexn.md
TXHEXN -- requirements
Module: txhexn

Interface
REQ-001 SHALL have parameter NHEX, default 8, number of hex digits per word (1..16).
REQ-002 SHALL have parameter PREFIX, default 1; 1 = emit "0x" before the digits.
REQ-003 SHALL have parameter EOL, default 2; 0 = none, 1 = "\n", 2 = "\r\n".
REQ-004 SHALL have parameter UPPER, default 0; 1 = digits a-f emitted as "A"-"F".
REQ-005 SHALL have parameter ZSUP, default 0; 1 = leading zero digits suppressed.
REQ-006 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_stb, input, 1, word request.
REQ-009 SHALL have port i_data, input, 4*NHEX, word to print, MS nibble first.
REQ-010 SHALL have port o_busy, output, 1, word in progress.
REQ-011 SHALL have port o_done, output, 1, one-cycle pulse when a word completes.
REQ-012 SHALL have port o_tx_stb, output, 1, byte valid toward a byte-serial transmitter.
REQ-013 SHALL have port o_tx_data, output, 8, ASCII byte.
REQ-014 SHALL have port i_tx_busy, input, 1, transmitter busy; byte accepted when o_tx_stb && !i_tx_busy.

Function
REQ-015 SHALL accept a word only on a rising edge where i_stb && !o_busy; i_data captured into an internal shift register that edge; i_stb while o_busy ignored.
REQ-016 SHALL, on the cycle after acceptance, assert o_busy and o_tx_stb and present the first byte.
REQ-017 SHALL emit in order: "0","x" (if PREFIX); digits; "\r" (if EOL==2); "\n" (if EOL>=1).
REQ-018 SHALL use states IDLE, PFX0, PFXX, DIGIT, CR, LF; unused states skipped per parameters; IDLE -> first enabled state on acceptance; last enabled state -> IDLE on byte acceptance.
REQ-019 SHALL advance exactly one byte per accept; next byte presented on the following cycle with o_tx_stb kept high (no idle cycle between bytes).
REQ-020 SHALL hold o_tx_data stable while o_tx_stb is high and the byte is not yet accepted.
REQ-021 SHALL, in DIGIT, use a digit counter of width clog2(NHEX+1); shift register left by 4 on each digit accept.
REQ-022 SHALL, with ZSUP=1, skip leading zero nibbles without emitting or stalling (skip resolved at capture via leading-zero count); an all-zero word emits exactly one "0".
REQ-023 SHALL, on acceptance of the final byte, drop o_tx_stb and o_busy the next cycle and pulse o_done for that one cycle.
REQ-024 SHALL allow a new i_stb to be accepted on the first cycle o_busy is low, giving back-to-back words with one idle cycle.
REQ-025 SHALL never assert o_tx_stb while o_busy is low.

Reset
REQ-026 SHALL, while i_reset_n is low, force state IDLE, o_busy=0, o_done=0, o_tx_stb=0, o_tx_data=8'h00, shift register and counter to 0, asynchronously and independent of i_clk.
REQ-027 SHALL, on reset mid-word, abandon the word with no further bytes; first acceptance permitted on the first clock edge after release.

Verification
REQ-028 Defaults, i_data=32'h12345678, i_tx_busy=0 -> bytes "0x12345678\r\n" (12 bytes) on 12 consecutive cycles, then o_done pulse.
REQ-029 Defaults, i_tx_busy high 5 cycles after each accept -> same 12 bytes; o_tx_data stable throughout every stall.
REQ-030 NHEX=4, PREFIX=0, EOL=0, UPPER=1, i_data=16'hBEEF -> "BEEF" only; o_busy high exactly 4 cycles with i_tx_busy=0.
REQ-031 ZSUP=1, i_data=32'h000000A0 -> "0xa0\r\n"; i_data=0 -> "0x0\r\n".
REQ-032 i_stb held high continuously with two i_data values -> second word begins only after o_done; no byte of the second word interleaves the first.
REQ-033 i_reset_n pulsed low after the 5th byte -> o_tx_stb and o_busy low immediately; next i_stb with 32'hDEADBEEF -> full "0xdeadbeef\r\n".
